// File: rtl/spi_m_tx.sv
// SPI mode-0 transmit-only master: byte stream in, NSS/SCLK/MOSI out, MSB first.
// Frames span bytes until one is qualified by i_tx_last; every output is a flop.
module spi_m_tx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_spi_mosi,
  output logic       o_spi_nss,
  output logic       o_spi_clk
);

  localparam int BIT_LEN = 2 * CLK_DIV;
  localparam int M1      = (CS_SETUP > BIT_LEN) ? CS_SETUP : BIT_LEN;
  localparam int M2      = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CMAX    = (M1 > M2) ? M1 : M2;
  localparam int CW      = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_NEXT, S_HOLD, S_GAP} state_t;

  state_t     r_state, w_state;
  cnt_t       r_cnt, w_cnt, w_cnt_inc;
  logic [2:0] r_bit, w_bit;
  logic [7:0] r_sh, w_sh;
  logic       r_last, w_last;
  logic       r_nss, r_sclk, r_mosi, r_ready, r_busy, r_done;
  logic       w_nss, w_sclk, w_mosi, w_ready, w_busy, w_done, w_xfer;

  assign w_cnt_inc = r_cnt + cnt_t'(1);
  assign w_xfer    = i_tx_valid & r_ready;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_sh    = r_sh;
    w_last  = r_last;
    w_nss   = r_nss;
    w_sclk  = r_sclk;
    w_mosi  = r_mosi;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nss   = 1'b1;
        w_sclk  = 1'b0;
        w_mosi  = 1'b0;
        w_ready = 1'b1;
        if (w_xfer) begin
          w_state = S_SETUP;
          w_cnt   = '0;
          w_sh    = i_tx_data;
          w_last  = i_tx_last;
          w_nss   = 1'b0;
          w_mosi  = i_tx_data[7];
          w_ready = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt == cnt_t'(CS_SETUP - 1)) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_bit   = '0;
        end else w_cnt = w_cnt_inc;
      end
      S_SHIFT: begin
        // bit cell: CLK_DIV cycles low then CLK_DIV high; MOSI moves only as SCLK falls
        if (r_cnt == cnt_t'(BIT_LEN - 1)) begin
          w_cnt  = '0;
          w_sclk = 1'b0;
          if (r_bit == 3'd7) begin
            w_state = r_last ? S_HOLD : S_NEXT;
            w_ready = ~r_last;
          end else begin
            w_bit  = r_bit + 3'd1;
            w_sh   = {r_sh[6:0], 1'b0};
            w_mosi = r_sh[6];
          end
        end else begin
          w_cnt  = w_cnt_inc;
          w_sclk = (w_cnt_inc >= cnt_t'(CLK_DIV));
        end
      end
      S_NEXT: begin
        w_ready = 1'b1;
        if (w_xfer) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_bit   = '0;
          w_sh    = i_tx_data;
          w_last  = i_tx_last;
          w_mosi  = i_tx_data[7];
          w_ready = 1'b0;
        end
      end
      S_HOLD: begin
        if (r_cnt == cnt_t'(CS_HOLD - 1)) begin
          w_state = S_GAP;
          w_cnt   = '0;
          w_nss   = 1'b1;
          w_mosi  = 1'b0;
          w_done  = 1'b1;
        end else w_cnt = w_cnt_inc;
      end
      S_GAP: begin
        // back-to-back frames see NSS high for CS_GAP cycles plus the accepting IDLE cycle
        if (r_cnt == cnt_t'(CS_GAP - 1)) begin
          w_state = S_IDLE;
          w_ready = 1'b1;
        end else w_cnt = w_cnt_inc;
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_last  <= 1'b0;
      r_nss   <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_sh    <= w_sh;
      r_last  <= w_last;
      r_nss   <= w_nss;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_ready <= w_ready;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign o_tx_ready = r_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_spi_mosi = r_mosi;
  assign o_spi_nss  = r_nss;
  assign o_spi_clk  = r_sclk;

endmodule
